// File: rtl/rf_bypass.sv
// Register file with two combinational read ports and one synchronous write port.
// A write-back in flight is bypassed to any read port that selects the same register.
module rf_bypass #(
  parameter int WIDTH  = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1RegSel,
  input  logic [ADDR_W-1:0] read2RegSel,
  input  logic [ADDR_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              writeEn,
  output logic [WIDTH-1:0]  read1Data,
  output logic [WIDTH-1:0]  read2Data,
  output logic              err
);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (writeEn) regs_d[writeRegSel] = writeData;
  end

  // NOTE: the whole array is cleared asynchronously, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass makes a same-cycle write-back visible to decode; reset overrides everything.
  always_comb begin
    read1Data = regs_q[read1RegSel];
    read2Data = regs_q[read2RegSel];
    if (writeEn && (writeRegSel == read1RegSel)) read1Data = writeData;
    if (writeEn && (writeRegSel == read2RegSel)) read2Data = writeData;
    if (rst) begin
      read1Data = '0;
      read2Data = '0;
    end
  end

  assign err = 1'b0;

endmodule
